// File: rtl/dac_arbiter.sv
// Two-requester arbiter feeding a 16-bit serial DAC: grants one frame at a time,
// shifts the captured word out MSB first, then holds SSYNC high for a fixed gap.
module dac_arbiter #(
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        req0,
  input  logic [15:0] data0,
  input  logic        req1,
  input  logic [15:0] data1,
  output logic        ack0,
  output logic        ack1,
  output logic        busy,
  output logic        frame_done,
  output logic        sclk,
  output logic        ssync,
  output logic        sdata
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);
  localparam logic [4:0] HALF_LAST = 5'd31;

  state_t      r_state, w_state;
  logic [7:0]  r_div, w_div;
  logic [4:0]  r_half, w_half;
  logic [15:0] r_shift, w_shift;
  logic        r_last, w_last;
  logic        r_ack0, w_ack0;
  logic        r_ack1, w_ack1;
  logic        r_busy, w_busy;
  logic        r_done, w_done;
  logic        r_sclk, w_sclk;
  logic        r_ssync, w_ssync;

  logic        w_grant;
  logic        w_sel1;
  logic [15:0] w_word;

  // On a tie the requester that did not win last time is served.
  assign w_sel1  = req1 & (~req0 | ~r_last);
  assign w_grant = en & (req0 | req1);
  assign w_word  = w_sel1 ? data1 : data0;

  always_comb begin
    w_state = r_state;
    w_div   = r_div;
    w_half  = r_half;
    w_shift = r_shift;
    w_last  = r_last;
    w_ack0  = 1'b0;
    w_ack1  = 1'b0;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_sclk  = r_sclk;
    w_ssync = r_ssync;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_state = SHIFT;
          w_div   = 8'd0;
          w_half  = 5'd0;
          w_shift = w_word;
          w_last  = w_sel1;
          w_ack0  = ~w_sel1;
          w_ack1  = w_sel1;
          w_busy  = 1'b1;
          w_ssync = 1'b0;
          w_sclk  = 1'b1;
        end
      end
      SHIFT: begin
        if (r_div == DIV_LAST) begin
          w_div  = 8'd0;
          w_sclk = ~r_sclk;
          // The 16th rising edge shifts in the last zero, so sdata idles low in GAP.
          if (!r_sclk) begin
            w_shift = {r_shift[14:0], 1'b0};
          end
          if (r_half == HALF_LAST) begin
            w_state = GAP;
            w_half  = 5'd0;
            w_ssync = 1'b1;
            w_done  = 1'b1;
          end else begin
            w_half = r_half + 5'd1;
          end
        end else begin
          w_div = r_div + 8'd1;
        end
      end
      GAP: begin
        if (r_div == GAP_LAST) begin
          w_state = IDLE;
          w_div   = 8'd0;
          w_busy  = 1'b0;
        end else begin
          w_div = r_div + 8'd1;
        end
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_div   <= 8'd0;
      r_half  <= 5'd0;
      r_shift <= 16'd0;
      r_last  <= 1'b1;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sclk  <= 1'b1;
      r_ssync <= 1'b1;
    end else begin
      r_state <= w_state;
      r_div   <= w_div;
      r_half  <= w_half;
      r_shift <= w_shift;
      r_last  <= w_last;
      r_ack0  <= w_ack0;
      r_ack1  <= w_ack1;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_sclk  <= w_sclk;
      r_ssync <= w_ssync;
    end
  end

  assign ack0       = r_ack0;
  assign ack1       = r_ack1;
  assign busy       = r_busy;
  assign frame_done = r_done;
  assign sclk       = r_sclk;
  assign ssync      = r_ssync;
  assign sdata      = r_shift[15];

endmodule

// File: tb/tb_dac_arbiter.sv
// Directed bench for dac_arbiter: a default-parameter instance plus a fast
// CLK_DIV=1 / GAP_CYCLES=1 instance, with a falling-edge DAC sampler on each.
module tb_dac_arbiter;

  logic        clk;
  logic        reset;
  logic        en, req0, req1;
  logic [15:0] data0, data1;
  logic        ack0, ack1, busy, frame_done, sclk, ssync, sdata;

  logic        enF, reqF0, reqF1;
  logic [15:0] dataF0, dataF1;
  logic        ackF0, ackF1, busyF, frame_doneF, sclkF, ssyncF, sdataF;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          falls = 0;
  int          fallsF = 0;
  logic [15:0] bits, bitsF;

  dac_arbiter u_dut (
    .clk(clk), .reset(reset), .en(en),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .ack0(ack0), .ack1(ack1), .busy(busy), .frame_done(frame_done),
    .sclk(sclk), .ssync(ssync), .sdata(sdata)
  );

  dac_arbiter #(.CLK_DIV(1), .GAP_CYCLES(1)) u_fast (
    .clk(clk), .reset(reset), .en(enF),
    .req0(reqF0), .data0(dataF0), .req1(reqF1), .data1(dataF1),
    .ack0(ackF0), .ack1(ackF1), .busy(busyF), .frame_done(frame_doneF),
    .sclk(sclkF), .ssync(ssyncF), .sdata(sdataF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // The DAC model samples sdata on every sclk falling edge; the last 16 samples form the word.
  always @(negedge sclk) begin
    bits  <= {bits[14:0], sdata};
    falls <= falls + 1;
  end

  always @(negedge sclkF) begin
    bitsF  <= {bitsF[14:0], sdataF};
    fallsF <= fallsF + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic r1, input logic e,
                               input logic [15:0] d0, input logic [15:0] d1);
    req0  = r0;
    req1  = r1;
    en    = e;
    data0 = d0;
    data1 = d1;
  endtask

  task automatic waitAck(output logic gotA0, output logic gotA1, output int at);
    gotA0 = 1'b0;
    gotA1 = 1'b0;
    at    = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        gotA0 = ack0;
        gotA1 = ack1;
        at    = cyc;
        break;
      end
    end
    checkOutput("ack_seen", 32'(gotA0 | gotA1), 32'd1);
  endtask

  // Call on the ack cycle; counts SSYNC-low cycles up to and including that one.
  task automatic waitDone(output int low);
    logic seen;
    seen = 1'b0;
    low  = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
      if (!ssync) low++;
    end
    checkOutput("done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    logic a0, a1;
    int   at, prevAt, low, f0, activity;

    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    enF = 1'b0; reqF0 = 1'b0; reqF1 = 1'b0; dataF0 = 16'h0000; dataF1 = 16'h0000;

    // Reset state
    @(negedge clk);
    checkOutput("rst_sclk", 32'(sclk), 32'd1);
    checkOutput("rst_ssync", 32'(ssync), 32'd1);
    checkOutput("rst_sdata", 32'(sdata), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_acks", 32'({ack0, ack1, frame_done}), 32'd0);
    reset = 1'b1;

    // Single frame from requester 0
    applyStimulus(1'b1, 1'b0, 1'b1, 16'hA5C3, 16'h0000);
    f0 = falls;
    @(negedge clk);
    checkOutput("f1_ack0", 32'(ack0), 32'd1);
    checkOutput("f1_ack1", 32'(ack1), 32'd0);
    checkOutput("f1_busy", 32'(busy), 32'd1);
    checkOutput("f1_ssync", 32'(ssync), 32'd0);
    checkOutput("f1_sclk", 32'(sclk), 32'd1);
    checkOutput("f1_msb", 32'(sdata), 32'd1);
    req0 = 1'b0;
    waitDone(low);
    checkOutput("f1_low", 32'(low), 32'd64);
    checkOutput("f1_falls", 32'(falls - f0), 32'd16);
    checkOutput("f1_bits", 32'(bits), 32'h0000A5C3);
    checkOutput("f1_gap_lines", 32'({sclk, sdata, ssync}), 32'b101);
    @(negedge clk);
    checkOutput("f1_done_pulse", 32'(frame_done), 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("f1_gap_busy", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("f1_idle_busy", 32'(busy), 32'd0);

    // Tie: pointer reset makes requester 0 win first, then alternation
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h1111, 16'h2222);
    prevAt = 0;
    for (int f = 0; f < 3; f++) begin
      waitAck(a0, a1, at);
      checkOutput("tie_ack0", 32'(a0), 32'((f % 2) == 0));
      checkOutput("tie_ack1", 32'(a1), 32'((f % 2) == 1));
      if (f > 0) checkOutput("tie_period", 32'(at - prevAt), 32'd69);
      prevAt = at;
      f0 = falls;
      if (f == 2) en = 1'b0;
      waitDone(low);
      checkOutput("tie_bits", 32'(bits), (f % 2) == 0 ? 32'h1111 : 32'h2222);
      checkOutput("tie_falls", 32'(falls - f0), 32'd16);
    end

    // en low stops new grants even with both requests pending
    activity = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack0 || ack1) activity++;
    end
    checkOutput("en_off_acks", 32'(activity), 32'd0);
    checkOutput("en_off_busy", 32'(busy), 32'd0);

    applyStimulus(1'b0, 1'b1, 1'b0, 16'h1111, 16'h3C5A);
    activity = 0;
    repeat (100) begin
      @(negedge clk);
      if (ack0 || ack1 || !ssync) activity++;
    end
    checkOutput("en_off_100", 32'(activity), 32'd0);
    en = 1'b1;
    @(negedge clk);
    checkOutput("en_on_ack1", 32'(ack1), 32'd1);
    checkOutput("en_on_ack0", 32'(ack0), 32'd0);

    // Reset in the 20th SHIFT cycle aborts the frame
    repeat (19) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("abort_lines", 32'({ssync, sclk, sdata}), 32'b110);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    f0 = falls;
    repeat (3) @(negedge clk);
    checkOutput("abort_no_falls", 32'(falls - f0), 32'd0);
    checkOutput("abort_sclk", 32'(sclk), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("regrant_ack1", 32'(ack1), 32'd1);
    req1 = 1'b0;
    f0 = falls;
    waitDone(low);
    checkOutput("regrant_bits", 32'(bits), 32'h3C5A);
    checkOutput("regrant_low", 32'(low), 32'd64);

    // Data changing after the ack leaves the frame intact
    applyStimulus(1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0000);
    waitAck(a0, a1, at);
    checkOutput("hold_ack0", 32'(a0), 32'd1);
    req0 = 1'b0;
    @(negedge clk);
    data0 = 16'h0000;
    waitDone(low);
    checkOutput("hold_bits", 32'(bits), 32'hFFFF);

    // Fast instance: CLK_DIV=1, GAP_CYCLES=1
    reqF0 = 1'b1; dataF0 = 16'h8001; enF = 1'b1;
    f0 = fallsF;
    @(negedge clk);
    checkOutput("fast_ack0", 32'(ackF0), 32'd1);
    checkOutput("fast_ack1", 32'(ackF1), 32'd0);
    reqF0 = 1'b0;
    low = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ssyncF) break;
      low++;
    end
    checkOutput("fast_low", 32'(low), 32'd32);
    checkOutput("fast_done", 32'(frame_doneF), 32'd1);
    checkOutput("fast_bits", 32'(bitsF), 32'h8001);
    checkOutput("fast_falls", 32'(fallsF - f0), 32'd16);
    @(negedge clk);
    checkOutput("fast_idle", 32'(busyF), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_arbiter.md
DAC_ARBITER -- requirements
Module: dac_arbiter

Interface
REQ-001 Parameter CLK_DIV, default 2: clk cycles per SCLK half-period; legal range 1..255.
REQ-002 Parameter GAP_CYCLES, default 4: clk cycles SSYNC is held high between frames; legal range 1..255.
REQ-003 Port clk  input  1: single system clock; all state changes on its rising edge.
REQ-004 Port reset  input  1: asynchronous, active-low reset.
REQ-005 Port en  input  1: high permits new grants; low blocks new grants only.
REQ-006 Port req0  input  1: requester 0 frame request; level, held until ack0.
REQ-007 Port data0  input  16: requester 0 DAC word; stable while req0 is high.
REQ-008 Port req1  input  1: requester 1 frame request; level, held until ack1.
REQ-009 Port data1  input  16: requester 1 DAC word; stable while req1 is high.
REQ-010 Port ack0  output  1: one-cycle pulse, data0 captured.
REQ-011 Port ack1  output  1: one-cycle pulse, data1 captured.
REQ-012 Port busy  output  1: high in every state except IDLE.
REQ-013 Port frame_done  output  1: one-cycle pulse on the first GAP cycle.
REQ-014 Port sclk  output  1: DAC serial clock; idles high.
REQ-015 Port ssync  output  1: DAC frame sync, active low; idles high.
REQ-016 Port sdata  output  1: DAC serial data, MSB first; idles 0.

Function
REQ-017 The state machine SHALL have exactly three states: IDLE, SHIFT and GAP. All outputs SHALL be registered.
REQ-018 In IDLE, a grant SHALL occur in cycle C when en=1 and (req0|req1)=1.
REQ-019 On a grant, the granted data word SHALL be captured into a 16-bit shift register at the end of cycle C.
REQ-020 In cycle C+1 the block SHALL be in SHIFT with ackN=1, busy=1, ssync=0, sclk=1 and sdata=bit15.
REQ-021 Arbitration: if only one req is high, that requester SHALL be granted.
REQ-022 Arbitration: if both reqs are high, the requester not granted last SHALL be granted.
REQ-023 The last-grant pointer SHALL update only on a grant; its reset value SHALL make requester 0 win the first tie.
REQ-024 In SHIFT, sclk SHALL toggle every CLK_DIV cycles, starting high.
REQ-025 sdata SHALL advance to the next lower bit only on an sclk 0->1 transition; the DAC samples on sclk falling edges.
REQ-026 SHIFT SHALL last exactly 32*CLK_DIV cycles, covering 16 falling edges.
REQ-027 On leaving SHIFT, the block SHALL hold sclk=1 and sdata=0 in GAP.
REQ-028 SHIFT SHALL exit to GAP; GAP SHALL set ssync=1.
REQ-029 GAP SHALL last exactly GAP_CYCLES cycles, then return to IDLE with busy=0.
REQ-030 A grant SHALL be possible in the first IDLE cycle after GAP.
REQ-031 A req held high past its ack SHALL be treated as a new request.
REQ-032 req, data and en changes during SHIFT or GAP SHALL NOT affect the current frame.
REQ-033 en falling mid-frame SHALL let the frame complete, after which the block remains in IDLE.
REQ-034 The bit counter SHALL be 5 bits and SHALL NOT wrap within a frame.
REQ-035 The divider counter SHALL be 8 bits, reload on terminal count and clear on state entry.
REQ-036 ack0 and ack1 SHALL never be high in the same cycle.
REQ-037 At most one ack SHALL occur per frame.

Reset
REQ-038 While reset=0, the block SHALL immediately and asynchronously force: state=IDLE, sclk=1, ssync=1, sdata=0, ack0=0, ack1=0, busy=0, frame_done=0, shift register=0, counters=0, pointer=requester 1.
REQ-039 Reset asserted mid-frame SHALL abort the frame with no further sclk edges.
REQ-040 After reset release, the first grant SHALL be possible on the first rising clk edge.

Verification (CLK_DIV=2, GAP_CYCLES=4)
REQ-041 req0=1, data0=16'hA5C3, en=1: ack0 pulses in cycle C+1; 16 falling sclk edges; sampled bits = A5C3 MSB first; ssync low for 64 cycles; frame_done one cycle later.
REQ-042 req0=req1=1 held continuously, data0=16'h1111, data1=16'h2222: frames alternate 1111, 2222, 1111, ...; frame start-to-start = 1+64+4 = 69 cycles.
REQ-043 en=0 with req1=1: no ack and ssync stays 1 for 100 cycles; en->1: ack1 in the next cycle.
REQ-044 reset=0 at the 20th cycle of SHIFT: ssync=1, sclk=1 and sdata=0 within the same cycle; busy=0; after release, req1 alone is granted normally.
REQ-045 Change data0 from 16'hFFFF to 16'h0000 one cycle after ack0: the serialized word remains FFFF.
REQ-046 CLK_DIV=1, GAP_CYCLES=1, data0=16'h8001: ssync low for exactly 32 cycles; bits 15 and 0 equal 1, all others 0.
